axi_stream_remove_header: RTL and testbench
===========================================

# axi_stream_remove_header

Downstream companion of the header-insert stage. It strips a per-packet count of leading bytes (0–3) from a 32-bit AXI-Stream packet, realigns the remaining bytes MSB-first across beat boundaries, and regenerates keep/last. It sits between the header-insert stage's output and the packet consumer, and shares its byte convention: byte 3 = data[31:24] is first on the wire, and keep is MSB-contiguous.

## Interface
- No parameters; data width fixed at 32 bits, keep at 4 bits.
- clk  input  1  the single clock for the block.
- rstn  input  1  asynchronous, active-low reset.
- valid_in  input  1  input beat valid.
- data_in  input  32  input data, MSB byte first.
- keep_in  input  4  1111 on non-last beats; 1000/1100/1110/1111 on the last beat.
- last_in  input  1  last beat of the packet.
- ready_in  output  1  input beat accepted when valid_in && ready_in.
- valid_remove  input  1  remove command valid, one per packet.
- byte_remove_cnt  input  2  number of leading bytes S (0–3) to drop.
- ready_remove  output  1  command accepted when valid_remove && ready_remove.
- valid_out, data_out[31:0], keep_out[3:0], last_out  output  registered output beat; unused low bytes are zero.
- ready_out  input  1  downstream ready.

## Operation
- Holding register H holds h valid bytes (1–4, MSB-aligned). S is latched from byte_remove_cnt on command acceptance.
- k is the byte count of keep_in (1000→1 … 1111→4).
- States:
  - IDLE: ready_remove=1, ready_in=0. On command handshake → HEAD.
  - HEAD: ready_in=1. First beat: H = data_in << 8·S, h = k−S.
    - If last_in: h>0 → FLUSH; h≤0 → IDLE (packet dropped, no output).
    - Else → STREAM.
  - STREAM: ready_in = !valid_out || ready_out. On a beat, let t = h+k.
    - Output data = {top h bytes of H, top 4−h bytes of data_in}.
    - Non-last: keep_out=1111, last_out=0; H takes the residual t−4 bytes; stay in STREAM.
    - last_in with t≤4: keep_out from t, last_out=1 → IDLE.
    - last_in with t>4: emit full beat with last_out=0; H gets t−4 bytes → FLUSH.
  - FLUSH: ready_in=0. When the output slot is free, emit H with keep from h, last_out=1 → IDLE.
- A non-1111 keep on a non-last beat, or an illegal keep pattern, is a protocol violation; behaviour is unspecified.

## Timing
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_remove=1; state IDLE; H=0.
- The command is accepted in cycle n. The first data beat can be accepted in cycle n+1 at the earliest.
- Output is registered:
  - the beat produced by an accepted input appears the next cycle;
  - the first output beat follows acceptance of the second input beat, or comes from FLUSH for single-beat packets.
- Output-slot rules:
  - The output slot loads only when !valid_out || ready_out. Full throughput is 1 beat/cycle with no bubbles while ready_out=1.
  - While valid_out=1 && ready_out=0, data_out, keep_out and last_out hold stable.
  - valid_out falls the cycle after the last handshake unless a new beat is loaded in the same cycle.
- A new command is accepted only in IDLE. A command presented during a packet waits.
- S=0 gives pass-through with a one-beat delay; H always holds a full beat.
- Reset asserted mid-packet aborts immediately to the reset values; partial data is discarded.

## Structure
- Package axi_stream_hdr_pkg:
  - state enum (IDLE, HEAD, STREAM, FLUSH);
  - keep-to-count function and count-to-keep function, shared with the insert stage.
- No sub-module; a single module of about 200 lines.

## Test plan
- S=2; beats 0x00112233, 0x44556677, 0x8899AABB (last), all keep 1111 → outputs 0x22334455/1111, 0x66778899/1111, 0xAABB0000/1100 with last_out=1.
- S=0; three full beats → identical data out, one-beat delay, last_out on the third beat.
- S=1; single beat 0xAABBCC00 keep 1110, last → one beat 0xBBCC0000, keep 1100, last_out=1; ready_remove returns to 1.
- S=2; single beat with keep 1100, last → no valid_out at all; the block is back in IDLE the next cycle.
- S=3; 20-beat packet with random ready_out and random valid_in gaps → byte stream equals the input minus 3 leading bytes, and outputs stay stable under stall.
- rstn pulsed low mid-packet → all outputs take their reset values; the next command and packet process correctly.

Source files
------------

// File: rtl/axi_stream_hdr_pkg.sv
// rtl/axi_stream_hdr_pkg.sv - shared state enum and keep/count helpers for the header stages
package axi_stream_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEAD   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  // keep is MSB-contiguous, so only four legal patterns map to a count
  function automatic logic [2:0] keep_to_cnt(input logic [3:0] keep);
    case (keep)
      4'b1000: keep_to_cnt = 3'd1;
      4'b1100: keep_to_cnt = 3'd2;
      4'b1110: keep_to_cnt = 3'd3;
      4'b1111: keep_to_cnt = 3'd4;
      default: keep_to_cnt = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] cnt_to_keep(input logic [2:0] cnt);
    case (cnt)
      3'd0:    cnt_to_keep = 4'b0000;
      3'd1:    cnt_to_keep = 4'b1000;
      3'd2:    cnt_to_keep = 4'b1100;
      3'd3:    cnt_to_keep = 4'b1110;
      default: cnt_to_keep = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] keep_to_mask(input logic [3:0] keep);
    keep_to_mask = {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
  endfunction

endpackage

// File: rtl/axi_stream_remove_header.sv
// rtl/axi_stream_remove_header.sv - strips 0-3 leading bytes from a 32-bit packet and realigns it
module axi_stream_remove_header
  import axi_stream_hdr_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  keep_in,
  input  logic        last_in,
  output logic        ready_in,
  input  logic        valid_remove,
  input  logic [1:0]  byte_remove_cnt,
  output logic        ready_remove,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic [3:0]  keep_out,
  output logic        last_out,
  input  logic        ready_out
);

  state_t      state, state_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic [2:0]  hcnt_q, hcnt_nxt;
  logic [1:0]  skip_q;

  logic        slot_free;
  logic [2:0]  kcnt;
  logic [3:0]  tcnt;
  logic [31:0] merged;
  logic [31:0] residual;
  logic [3:0]  tail_keep;
  logic [3:0]  flush_keep;

  logic        load;
  logic [31:0] ld_data;
  logic [3:0]  ld_keep;
  logic        ld_last;

  assign slot_free  = !valid_out || ready_out;
  assign kcnt       = keep_to_cnt(keep_in);
  assign tcnt       = {1'b0, hcnt_q} + {1'b0, kcnt};
  assign tail_keep  = cnt_to_keep(tcnt[2:0]);
  assign flush_keep = cnt_to_keep(hcnt_q);

  // Top h bytes come from H, the rest from the head of the new beat;
  // whatever of the new beat did not fit moves up to become the next H.
  assign merged   = (hold_q & keep_to_mask(flush_keep)) | (data_in >> {hcnt_q, 3'b000});
  assign residual = data_in << {3'd4 - hcnt_q, 3'b000};

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_q;
    hcnt_nxt     = hcnt_q;
    ready_in     = 1'b0;
    ready_remove = 1'b0;
    load         = 1'b0;
    ld_data      = 32'd0;
    ld_keep      = 4'd0;
    ld_last      = 1'b0;
    case (state)
      IDLE: begin
        ready_remove = 1'b1;
        if (valid_remove) state_nxt = HEAD;
      end
      HEAD: begin
        ready_in = 1'b1;
        if (valid_in) begin
          hold_nxt = data_in << {skip_q, 3'b000};
          hcnt_nxt = (kcnt > {1'b0, skip_q}) ? kcnt - {1'b0, skip_q} : 3'd0;
          if (last_in)
            state_nxt = (kcnt > {1'b0, skip_q}) ? FLUSH : IDLE;
          else
            state_nxt = STREAM;
        end
      end
      STREAM: begin
        ready_in = slot_free;
        if (valid_in && slot_free) begin
          load = 1'b1;
          if (last_in && tcnt <= 4'd4) begin
            ld_data   = merged & keep_to_mask(tail_keep);
            ld_keep   = tail_keep;
            ld_last   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ld_data  = merged;
            ld_keep  = 4'b1111;
            hold_nxt = residual;
            if (last_in) begin
              hcnt_nxt  = 3'(tcnt - 4'd4);
              state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load      = 1'b1;
          ld_data   = hold_q & keep_to_mask(flush_keep);
          ld_keep   = flush_keep;
          ld_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      hold_q <= 32'd0;
      hcnt_q <= 3'd0;
      skip_q <= 2'd0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_nxt;
      hcnt_q <= hcnt_nxt;
      if (state == IDLE && valid_remove) skip_q <= byte_remove_cnt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      data_out  <= 32'd0;
      keep_out  <= 4'd0;
      last_out  <= 1'b0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= ld_data;
      keep_out  <= ld_keep;
      last_out  <= ld_last;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb/tb_axi_stream_remove_header.sv - scoreboard bench for axi_stream_remove_header
module tb_axi_stream_remove_header;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [3:0]  keep_in = 4'd0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_remove = 1'b0;
  logic [1:0]  byte_remove_cnt = 2'd0;
  logic        ready_remove;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    rand_ready = 0;

  axi_stream_remove_header dut (
    .clk(clk), .rstn(rstn),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt),
    .ready_remove(ready_remove),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: handshakes are judged at the negedge, where inputs and outputs are settled.
  initial begin
    beat_t cur, prev, e;
    bit    prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {data_out, keep_out, last_out};
      if (!rstn) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          n_checks++;
          if (cur !== prev) begin
            n_fail++;
            $display("FAIL stall_hold: got %h/%b/%b required %h/%b/%b",
                     cur.d, cur.k, cur.l, prev.d, prev.k, prev.l);
          end
        end
        if (valid_out && ready_out) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got %h/%b/%b required no beat", cur.d, cur.k, cur.l);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL out_beat: got %h/%b/%b required %h/%b/%b",
                       cur.d, cur.k, cur.l, e.d, e.k, e.l);
            end
          end
        end
        prev_stall = valid_out && !ready_out;
        prev = cur;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({d, k, l});
  endtask

  task automatic send_cmd(input logic [1:0] s);
    bit hs;
    hs = 0;
    valid_remove = 1'b1;
    byte_remove_cnt = s;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = ready_remove;
      @(posedge clk);
      #1;
    end
    valid_remove = 1'b0;
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_timeout: got no ready_remove required handshake");
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input int gap);
    bit hs;
    hs = 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    valid_in = 1'b1;
    data_in = d;
    keep_in = k;
    last_in = l;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = ready_in;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: got no ready_in required handshake");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0]  bytes [0:79];
  logic [31:0] w;
  int          nb, nout;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_keep_out", 32'(keep_out), 32'd0);
    check("rst_last_out", 32'(last_out), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd0);
    check("rst_ready_remove", 32'(ready_remove), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // S=2 three full beats
    push(32'h22334455, 4'b1111, 1'b0);
    push(32'h66778899, 4'b1111, 1'b0);
    push(32'hAABB0000, 4'b1100, 1'b1);
    send_cmd(2'd2);
    check("busy_ready_remove", 32'(ready_remove), 32'd0);
    send_beat(32'h00112233, 4'b1111, 1'b0, 0);
    send_beat(32'h44556677, 4'b1111, 1'b0, 0);
    send_beat(32'h8899AABB, 4'b1111, 1'b1, 0);
    drain();

    // S=0 pass-through, one-beat delay
    push(32'h01234567, 4'b1111, 1'b0);
    push(32'h89ABCDEF, 4'b1111, 1'b0);
    push(32'hDEADBEEF, 4'b1111, 1'b1);
    send_cmd(2'd0);
    send_beat(32'h01234567, 4'b1111, 1'b0, 0);
    check("s0_no_early_out", 32'(valid_out), 32'd0);
    send_beat(32'h89ABCDEF, 4'b1111, 1'b0, 0);
    check("s0_delay_valid", 32'(valid_out), 32'd1);
    check("s0_delay_data", data_out, 32'h01234567);
    send_beat(32'hDEADBEEF, 4'b1111, 1'b1, 0);
    drain();

    // S=1 single short beat goes out through FLUSH
    push(32'hBBCC0000, 4'b1100, 1'b1);
    send_cmd(2'd1);
    send_beat(32'hAABBCC00, 4'b1110, 1'b1, 0);
    drain();
    check("s1_ready_remove", 32'(ready_remove), 32'd1);

    // S=2 with only two bytes: packet vanishes
    send_cmd(2'd2);
    send_beat(32'hCAFE0000, 4'b1100, 1'b1, 0);
    check("drop_ready_remove", 32'(ready_remove), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("drop_no_valid", 32'(valid_out), 32'd0);
      @(posedge clk);
      #1;
    end

    // S=3, 20 beats (last keep 1100), random stalls and gaps
    for (int b = 0; b < 80; b++) bytes[b] = 8'(b * 13 + 5);
    nb = 78;
    nout = 0;
    w = 32'd0;
    for (int b = 3; b < nb; b++) begin
      w[31 - 8 * (nout % 4) -: 8] = bytes[b];
      nout++;
      if (nout % 4 == 0) begin
        push(w, 4'b1111, (b == nb - 1) ? 1'b1 : 1'b0);
        w = 32'd0;
      end
    end
    if (nout % 4 != 0) push(w, (nout % 4 == 3) ? 4'b1110 : (nout % 4 == 2) ? 4'b1100 : 4'b1000, 1'b1);
    rand_ready = 1;
    send_cmd(2'd3);
    for (int j = 0; j < 20; j++) begin
      if (j == 19)
        send_beat({bytes[76], bytes[77], 8'h5A, 8'hA5}, 4'b1100, 1'b1, $urandom_range(0, 2));
      else
        send_beat({bytes[4*j], bytes[4*j+1], bytes[4*j+2], bytes[4*j+3]}, 4'b1111, 1'b0,
                  $urandom_range(0, 2));
    end
    drain();
    rand_ready = 0;
    @(posedge clk);
    #1;

    // Reset mid-packet with an output beat pending
    send_cmd(2'd1);
    send_beat(32'h11223344, 4'b1111, 1'b0, 0);
    send_beat(32'h55667788, 4'b1111, 1'b0, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid_out", 32'(valid_out), 32'd0);
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_keep_out", 32'(keep_out), 32'd0);
    check("mid_rst_ready_in", 32'(ready_in), 32'd0);
    check("mid_rst_ready_remove", 32'(ready_remove), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    push(32'h03040506, 4'b1111, 1'b0);
    push(32'h07000000, 4'b1000, 1'b1);
    send_cmd(2'd2);
    send_beat(32'h01020304, 4'b1111, 1'b0, 0);
    send_beat(32'h050607FF, 4'b1110, 1'b1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
